// File: rtl/pc_redirect_ctrl.sv
// Multicycle sequencer for control-flow PC updates (J, JAL, BEQ, BNE, JR, JALR):
// latches the request, decodes it, optionally writes the link register, then commits the new PC.
module pc_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rd,
  input  logic             alu_zero,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      rs_value,
  output logic             busy,
  output logic             done,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [31:0]      pc_next,
  output logic             link_write,
  output logic [4:0]       link_addr,
  output logic [31:0]      link_data,
  output logic             illegal,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_LINK   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  state_e           state_q;
  logic [5:0]       op_q, funct_q;
  logic [4:0]       rd_q;
  logic             zero_q, taken_q;
  logic [31:0]      pc_q, jt_q, bt_q, rs_q;
  logic             busy_q, done_q, pc_write_q, link_write_q, illegal_q, misaligned_q;
  logic [1:0]       pc_src_q;
  logic [31:0]      pc_next_q, link_data_q;
  logic [4:0]       link_addr_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0]  src_d;
  logic        taken_d, link_d, illegal_d, mis_d;
  logic [31:0] pc_next_d;
  logic [4:0]  link_addr_d;

  // Decode of the latched instruction fields; only consumed in EVAL.
  always_comb begin
    src_d     = 2'd0;
    taken_d   = 1'b0;
    link_d    = 1'b0;
    illegal_d = 1'b0;
    mis_d     = 1'b0;
    case (op_q)
      6'h02: begin src_d = 2'd2; taken_d = 1'b1; end
      6'h03: begin src_d = 2'd2; taken_d = 1'b1; link_d = 1'b1; end
      6'h04: begin
        if (zero_q) begin src_d = 2'd1; taken_d = 1'b1; end
        else        begin src_d = 2'd0; taken_d = 1'b0; end
      end
      6'h05: begin
        if (!zero_q) begin src_d = 2'd1; taken_d = 1'b1; end
        else         begin src_d = 2'd0; taken_d = 1'b0; end
      end
      6'h00: begin
        case (funct_q)
          6'h08, 6'h09: begin
            if (rs_q[1:0] != 2'b00) begin
              mis_d = 1'b1;
            end else begin
              src_d   = 2'd3;
              taken_d = 1'b1;
              // JALR to $zero has nothing to link, so LINK is skipped.
              link_d  = (funct_q == 6'h09) && (rd_q != 5'd0);
            end
          end
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase

    case (src_d)
      2'd1:    pc_next_d = bt_q;
      2'd2:    pc_next_d = jt_q;
      2'd3:    pc_next_d = rs_q;
      default: pc_next_d = pc_q;
    endcase

    if (op_q == 6'h03) link_addr_d = 5'd31;
    else               link_addr_d = rd_q;
  end

  // Sequencer state, request latches and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 6'd0;
      funct_q      <= 6'd0;
      rd_q         <= 5'd0;
      zero_q       <= 1'b0;
      taken_q      <= 1'b0;
      pc_q         <= 32'd0;
      jt_q         <= 32'd0;
      bt_q         <= 32'd0;
      rs_q         <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pc_write_q   <= 1'b0;
      link_write_q <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      pc_src_q     <= 2'd0;
      pc_next_q    <= 32'd0;
      link_data_q  <= 32'd0;
      link_addr_q  <= 5'd0;
      count_q      <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q         <= opcode;
            funct_q      <= funct;
            rd_q         <= rd;
            zero_q       <= alu_zero;
            pc_q         <= pc_in;
            jt_q         <= jump_target;
            bt_q         <= branch_target;
            rs_q         <= rs_value;
            link_data_q  <= pc_in;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_EVAL;
          end
        end
        S_EVAL: begin
          pc_src_q     <= src_d;
          pc_next_q    <= pc_next_d;
          taken_q      <= taken_d;
          illegal_q    <= illegal_d;
          misaligned_q <= mis_d;
          link_addr_q  <= link_addr_d;
          if (link_d) begin
            link_write_q <= 1'b1;
            state_q      <= S_LINK;
          end else begin
            done_q     <= 1'b1;
            pc_write_q <= taken_d;
            if (taken_d) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q    <= S_COMMIT;
          end
        end
        S_LINK: begin
          link_write_q <= 1'b0;
          done_q       <= 1'b1;
          pc_write_q   <= taken_q;
          if (taken_q) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_q      <= S_COMMIT;
        end
        S_COMMIT: begin
          done_q     <= 1'b0;
          pc_write_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pc_write       = pc_write_q;
  assign pc_src         = pc_src_q;
  assign pc_next        = pc_next_q;
  assign link_write     = link_write_q;
  assign link_addr      = link_addr_q;
  assign link_data      = link_data_q;
  assign illegal        = illegal_q;
  assign misaligned     = misaligned_q;
  assign redirect_count = count_q;

endmodule
